// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default datapath widths and the reader FSM state encoding,
// used by both the load path and the result reader.
package tpu_pkg;

  localparam int DATAWITH   = 16;
  localparam int ADDR_WIDTH = 10;
  localparam int ARRAY_SIZE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with a registered head word: pop_data_o comes straight from a flop,
// and a push and pop in the same cycle are accepted at any occupancy, full included.
module result_fifo #(
  parameter  int width = 16,
  parameter  int depth = 4,
  localparam int ptr_w = $clog2(depth),
  localparam int cnt_w = $clog2(depth) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [cnt_w-1:0] count_o
);

  localparam logic [cnt_w-1:0] FULL_CNT = cnt_w'(depth);

  logic [width-1:0] mem_q [depth];
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w-1:0] count_q, count_d, remain;
  logic [width-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + ptr_w'(do_pop);
    wr_ptr_d = wr_ptr_q + ptr_w'(do_push);
    remain   = count_q - cnt_w'(do_pop);
    count_d  = remain + cnt_w'(do_push);
    head_d   = head_q;
    // The head flop reloads from the bypassed push word when the FIFO would otherwise
    // be empty, else from the stored entry that becomes the new head.
    if (do_push && (remain == '0)) begin
      head_d = push_data_i;
    end else if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: storage carries no reset; validity is tracked by count_q alone, so the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign pop_data_o = head_q;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/tpu_result_reader.sv
// Walks a contiguous window of the result SRAM, absorbs the one-cycle read latency in
// result_fifo and streams the words out on a valid/ready interface.
module tpu_result_reader
  import tpu_pkg::*;
#(
  parameter int datawith   = DATAWITH,
  parameter int array_size = ARRAY_SIZE,
  parameter int addr_width = ADDR_WIDTH,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   count,
  output logic                  mem_rd_en,
  output logic [addr_width-1:0] mem_rd_addr,
  input  logic [datawith-1:0]   mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [datawith-1:0]   out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int cnt_w = $clog2(fifo_depth) + 1;
  localparam logic [addr_width:0]   CNT_ONE   = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] ADDR_ONE  = addr_width'(1);
  localparam logic [cnt_w:0]        DEPTH_CNT = (cnt_w + 1)'(fifo_depth);

  if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
    $error("fifo_depth must be a power of two and at least 2");
  end
  if (array_size * array_size >= (1 << (addr_width + 1))) begin : g_bad_count
    $error("array_size*array_size does not fit the count port");
  end

  rd_state_e             state_q, state_d;
  logic [addr_width-1:0] addr_q;
  logic [addr_width:0]   issue_q;
  logic [addr_width:0]   deliver_q;
  logic                  inflight_q;
  logic [cnt_w-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  handshake, can_issue;

  assign handshake = out_valid && out_ready;
  // Room is judged on words already owned (FIFO plus the read in flight); a same-cycle
  // pop is not credited, so the FIFO can never overflow.
  assign can_issue = (issue_q != '0) && !fifo_full &&
                     (({1'b0, fifo_count} + (cnt_w + 1)'(inflight_q)) < DEPTH_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (count == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (mem_rd_en && (issue_q == CNT_ONE)) state_d = ST_DRAIN;
      ST_DRAIN: if (handshake && out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE:  ;
      ST_READ:  begin busy = 1'b1; mem_rd_en = can_issue; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      issue_q    <= '0;
      deliver_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if ((state_q == ST_IDLE) && start) begin
        addr_q    <= base_addr;
        issue_q   <= count;
        deliver_q <= count;
      end else begin
        if (mem_rd_en) begin
          addr_q  <= addr_q + ADDR_ONE;
          issue_q <= issue_q - CNT_ONE;
        end
        if (handshake) begin
          deliver_q <= deliver_q - CNT_ONE;
        end
      end
    end
  end

  result_fifo #(
    .width (datawith),
    .depth (fifo_depth)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (mem_rd_data),
    .pop_i       (handshake),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign mem_rd_addr = addr_q;
  assign out_valid   = !fifo_empty;
  assign out_last    = out_valid && (deliver_q == CNT_ONE);

endmodule

// File: tb/tb_tpu_result_reader.sv
// Bench for tpu_result_reader: SRAM model, directed and random transfers checked
// against an expected-word queue built from the SRAM contents and the window rules.
module tb_tpu_result_reader;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid, out_last, busy, done;
  logic [DW-1:0] out_data;

  logic [DW-1:0] sram [1024];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr];
  end

  tpu_result_reader #(
    .datawith   (DW),
    .array_size (2),
    .addr_width (AW),
    .fifo_depth (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode 0: ready always high (exact latency checked); 1: ready low on edges T+3..T+10;
  // 2: random ready. repulse re-asserts start mid-transfer; abort resets after word 2.
  task automatic run_xfer(input logic [AW-1:0] b, input int n, input int mode,
                          input bit repulse, input bit abort);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] st_data, w;
    logic          st_last;
    bit            stalled = 0, aborted = 0;
    int            issued = 0, delivered = 0, done_j = -1, last_hs_j = -1;

    for (int i = 0; i < n; i++) expq.push_back(sram[(int'(b) + i) % 1024]);

    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    count     = (AW + 1)'(n);

    for (int j = 1; j <= 120 && done_j < 0 && !aborted; j++) begin
      @(negedge clk);
      start     = repulse && (j == 2);
      base_addr = b ^ 10'h155;
      count     = (AW + 1)'(n + 5);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(j >= 3 && j <= 10);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase

      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, st_data);
        check("stall_last", out_last, st_last);
      end

      if (mem_rd_en) begin
        check("rd_addr", mem_rd_addr, (int'(b) + issued) % 1024);
        check("rd_in_window", issued < n, 1);
        check("rd_fifo_room", (issued - delivered) < DEPTH, 1);
        if (mode == 0) check("rd_cycle", j, issued + 1);
        issued++;
      end

      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          w = expq.pop_front();
          check("out_data", out_data, w);
          check("out_last", out_last, expq.size() == 0);
        end
        if (mode == 0) check("hs_cycle", j, delivered + 3);
        delivered++;
        last_hs_j = j;
        if (abort && delivered == 2) aborted = 1;
      end

      stalled = out_valid && !out_ready;
      st_data = out_data;
      st_last = out_last;
      check("busy", busy, (n != 0) && !done);
      if (done) done_j = j;
    end

    start     = 1'b0;
    base_addr = b;

    if (abort) begin
      check("abort_reached", aborted, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("abort_rst");
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check("post_abort_valid", out_valid, 0);
        check("post_abort_done", done, 0);
        check("post_abort_rd", mem_rd_en, 0);
      end
    end else begin
      check("timeout", done_j > 0, 1);
      check("n_issued", issued, n);
      check("n_delivered", delivered, n);
      if (n == 0) check("done_cycle_zero", done_j, 1);
      else        check("done_after_last", done_j, last_hs_j + 1);
      if (mode == 0 && n > 0) check("done_cycle", done_j, n + 3);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) sram[i] = DW'($urandom);
    sram[32] = 16'h0011;
    sram[33] = 16'h0022;
    sram[34] = 16'h0033;
    sram[35] = 16'h0044;

    repeat (3) @(negedge clk);
    check_reset_values("init_rst");
    reset = 1'b0;

    run_xfer(10'd32, 4, 0, 1'b0, 1'b0);
    run_xfer(10'd32, 4, 1, 1'b0, 1'b0);
    run_xfer(10'd1022, 4, 0, 1'b0, 1'b0);
    run_xfer(10'd5, 0, 0, 1'b0, 1'b0);
    run_xfer(10'd32, 4, 0, 1'b1, 1'b0);
    run_xfer(10'd200, 10, 1, 1'b0, 1'b0);
    run_xfer(10'd32, 4, 0, 1'b0, 1'b1);
    run_xfer(10'd32, 4, 0, 1'b0, 1'b0);
    run_xfer(10'd1020, 9, 2, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      run_xfer(AW'($urandom_range(0, 1023)), $urandom_range(1, 12), 2, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
